// File: rtl/sccomp_dbg_pkg.sv
// sccomp_dbg_pkg: shared state, halt-reason encodings and register count for the sccomp debug controller
package sccomp_dbg_pkg;
   localparam int NREG = 32;
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_HALT, S_DUMP} state_e;
   typedef enum logic [1:0] {HR_NONE = 2'd0, HR_CMD = 2'd1, HR_BP = 2'd2, HR_LIMIT = 2'd3} halt_reason_e;
endpackage

// File: rtl/sccomp_rf_dumper.sv
// sccomp_rf_dumper: walks reg_sel over the register file and presents each value as a valid/ready beat
module sccomp_rf_dumper import sccomp_dbg_pkg::*; #(
   parameter int XLEN = 32,
   parameter int NREG = sccomp_dbg_pkg::NREG
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start_i,
   output logic                    done_o,
   output logic [$clog2(NREG)-1:0] reg_sel_o,
   input  logic [XLEN-1:0]         reg_data_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [$clog2(NREG)-1:0] idx_o,
   output logic [XLEN-1:0]         data_o,
   output logic                    last_o
);
   localparam int IW = $clog2(NREG);
   logic          act_q, act_d, vld_q, vld_d;
   logic [IW-1:0] k_q, k_d;
   logic [XLEN-1:0] data_q, data_d;
   logic          at_last;
   assign at_last   = k_q == IW'(NREG - 1);
   assign reg_sel_o = k_q;
   assign idx_o     = k_q;
   assign valid_o   = vld_q;
   assign data_o    = data_q;
   assign last_o    = vld_q && at_last;
   // Select phase captures reg_data into the beat; acceptance advances to the next index
   always_comb begin
      act_d  = act_q;
      vld_d  = vld_q;
      k_d    = k_q;
      data_d = data_q;
      done_o = act_q && vld_q && ready_i && at_last;
      if (!act_q) begin
         act_d = start_i;
         k_d   = '0;
      end else if (!vld_q) begin
         vld_d  = 1'b1;
         data_d = reg_data_i;
      end else if (ready_i) begin
         vld_d = 1'b0;
         act_d = !done_o;
         k_d   = done_o ? '0 : k_q + 1'b1;
      end
   end
   // Beat and sequencing registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_q  <= 1'b0;
         vld_q  <= 1'b0;
         k_q    <= '0;
         data_q <= '0;
      end else begin
         act_q  <= act_d;
         vld_q  <= vld_d;
         k_q    <= k_d;
         data_q <= data_d;
      end
   end
endmodule

// File: rtl/sccomp_run_ctrl.sv
// sccomp_run_ctrl: run/step/halt/breakpoint/limit control and register dump sequencing for sccomp
module sccomp_run_ctrl import sccomp_dbg_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int NREG  = sccomp_dbg_pkg::NREG,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_run,
   input  logic                    cmd_step,
   input  logic                    cmd_halt,
   input  logic                    cmd_dump,
   input  logic                    bp_en,
   input  logic [XLEN-1:0]         bp_addr,
   input  logic [CNT_W-1:0]        max_commits,
   input  logic [XLEN-1:0]         pc,
   input  logic [XLEN-1:0]         reg_data,
   output logic                    cpu_en,
   output logic [$clog2(NREG)-1:0] reg_sel,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [$clog2(NREG)-1:0] dump_idx,
   output logic [XLEN-1:0]         dump_data,
   output logic                    dump_last,
   output logic [CNT_W-1:0]        commit_cnt,
   output logic                    halted,
   output logic [1:0]              halt_reason,
   output logic                    busy
);
   state_e         state_q, state_d, ret_q, ret_d;
   halt_reason_e   reason_q, reason_d;
   logic           skip_q, skip_d;
   logic [CNT_W-1:0] cnt_q;
   logic           bp_hit, limit_hit, dump_start, dump_done;
   assign bp_hit      = bp_en && pc == bp_addr && !skip_q;
   assign limit_hit   = max_commits != '0 && cnt_q + CNT_W'(1) == max_commits;
   assign cpu_en      = state_q == S_STEP || (state_q == S_RUN && !bp_hit && !cmd_halt);
   assign commit_cnt  = cnt_q;
   assign halted      = state_q == S_HALT;
   assign halt_reason = reason_q;
   assign busy        = state_q inside {S_RUN, S_STEP, S_DUMP};
   // Next state: halt beats step beats run beats dump; skip_bp lives until the first commit
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      reason_d   = reason_q;
      skip_d     = cpu_en ? 1'b0 : skip_q;
      dump_start = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (cmd_halt) begin
               state_d = state_q;
            end else if (cmd_step || cmd_run) begin
               state_d  = cmd_step ? S_STEP : S_RUN;
               reason_d = HR_NONE;
               skip_d   = reason_q == HR_BP;
            end else if (cmd_dump) begin
               state_d    = S_DUMP;
               ret_d      = state_q;
               dump_start = 1'b1;
            end
         end
         S_STEP: begin
            state_d  = S_HALT;
            reason_d = HR_CMD;
         end
         S_RUN: begin
            if (cmd_halt || bp_hit || limit_hit) begin
               state_d  = S_HALT;
               reason_d = cmd_halt ? HR_CMD : bp_hit ? HR_BP : HR_LIMIT;
            end
         end
         S_DUMP: state_d = dump_done ? ret_q : S_DUMP;
         default: state_d = S_IDLE;
      endcase
   end
   // Controller state and commit counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         reason_q <= HR_NONE;
         skip_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         reason_q <= reason_d;
         skip_q   <= skip_d;
         cnt_q    <= cnt_q + CNT_W'(cpu_en);
      end
   end
   sccomp_rf_dumper #(.XLEN(XLEN), .NREG(NREG)) u_dumper (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (dump_start),
      .done_o     (dump_done),
      .reg_sel_o  (reg_sel),
      .reg_data_i (reg_data),
      .ready_i    (dump_ready),
      .valid_o    (dump_valid),
      .idx_o      (dump_idx),
      .data_o     (dump_data),
      .last_o     (dump_last)
   );
endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// tb_sccomp_run_ctrl: sccomp PC/RF model plus dump scoreboard driving the run controller
module tb_sccomp_run_ctrl;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_dump = 1'b0;
   logic        bp_en = 1'b0, dump_ready = 1'b0;
   logic [31:0] bp_addr = '0, max_commits = '0;
   logic [31:0] pc, reg_data, dump_data, commit_cnt, tb_commits;
   logic        cpu_en, dump_valid, dump_last, halted, busy;
   logic [4:0]  reg_sel, dump_idx;
   logic [1:0]  halt_reason;
   logic [31:0] rf [32];
   typedef struct packed {logic last; logic [4:0] idx; logic [31:0] data;} beat_t;
   beat_t sb[$];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign reg_data = rf[reg_sel];

   always @(posedge clk or negedge rstn)
      if (!rstn) begin
         pc <= '0;
         tb_commits <= '0;
      end else if (cpu_en) begin
         pc <= pc + 32'd4;
         tb_commits <= tb_commits + 32'd1;
      end

   sccomp_run_ctrl dut (
      .clk(clk), .rstn(rstn), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
      .cmd_dump(cmd_dump), .bp_en(bp_en), .bp_addr(bp_addr), .max_commits(max_commits),
      .pc(pc), .reg_data(reg_data), .cpu_en(cpu_en), .reg_sel(reg_sel), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
      .commit_cnt(commit_cnt), .halted(halted), .halt_reason(halt_reason), .busy(busy)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();
   endtask

   task automatic run_until_halt(input int budget);
      cmd_run = 1'b1;
      cyc();
      cmd_run = 1'b0;
      for (int c = 0; c < budget && !halted; c++) cyc();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout: halted=%b want 1", halted); end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
      checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt); end
      checks++; if (halted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_state: halted=%b busy=%b want 0 0", halted, busy); end
      checks++; if (halt_reason !== 2'd0) begin errors++; $display("FAIL reset_reason: got %0d want 0", halt_reason); end
      checks++; if (dump_valid !== 1'b0 || dump_last !== 1'b0 || dump_data !== 32'd0 || dump_idx !== 5'd0 || reg_sel !== 5'd0)
         begin errors++; $display("FAIL reset_dump: valid=%b last=%b data=%h idx=%0d sel=%0d want all 0", dump_valid, dump_last, dump_data, dump_idx, reg_sel); end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_step;
      for (int s = 1; s <= 3; s++) begin
         cmd_step = 1'b1;
         cyc();
         cmd_step = 1'b0;
         @(negedge clk);
         checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_en[%0d]: got %b want 1", s, cpu_en); end
         cyc();
         checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL step_halt[%0d]: cpu_en=%b halted=%b want 0 1", s, cpu_en, halted); end
         checks++; if (tb_commits !== 32'(s)) begin errors++; $display("FAIL step_commits[%0d]: got %0d want %0d", s, tb_commits, s); end
      end
      checks++; if (commit_cnt !== 32'd3) begin errors++; $display("FAIL step_cnt: got %0d want 3", commit_cnt); end
      checks++; if (halt_reason !== 2'd1) begin errors++; $display("FAIL step_reason: got %0d want 1", halt_reason); end
   endtask

   task automatic test_breakpoint;
      bp_en = 1'b1;
      bp_addr = 32'h198;
      run_until_halt(1000);
      checks++; if (pc !== 32'h198) begin errors++; $display("FAIL bp_pc: got %h want 198", pc); end
      checks++; if (commit_cnt !== 32'd102) begin errors++; $display("FAIL bp_cnt: got %0d want 102", commit_cnt); end
      checks++; if (halt_reason !== 2'd2) begin errors++; $display("FAIL bp_reason: got %0d want 2", halt_reason); end
      cmd_run = 1'b1;
      cyc();
      cmd_run = 1'b0;
      checks++; if (busy !== 1'b1 || halt_reason !== 2'd0) begin errors++; $display("FAIL bp_resume: busy=%b reason=%0d want 1 0", busy, halt_reason); end
      repeat (5) cyc();
      checks++; if (pc !== 32'h1ac || busy !== 1'b1) begin errors++; $display("FAIL bp_pass: pc=%h busy=%b want 1ac 1", pc, busy); end
   endtask

   task automatic test_halt_run;
      cmd_halt = 1'b1;
      cmd_run = 1'b1;
      @(negedge clk);
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL hr_cpu_en: got %b want 0", cpu_en); end
      cyc();
      cmd_halt = 1'b0;
      cmd_run = 1'b0;
      checks++; if (halted !== 1'b1 || halt_reason !== 2'd1) begin errors++; $display("FAIL hr_state: halted=%b reason=%0d want 1 1", halted, halt_reason); end
      checks++; if (pc !== 32'h1ac) begin errors++; $display("FAIL hr_pc: got %h want 1ac", pc); end
   endtask

   task automatic test_limit;
      do_reset();
      bp_en = 1'b0;
      max_commits = 32'd1000;
      run_until_halt(2000);
      checks++; if (commit_cnt !== 32'd1000 || tb_commits !== 32'd1000) begin errors++; $display("FAIL lim_cnt: cnt=%0d commits=%0d want 1000", commit_cnt, tb_commits); end
      checks++; if (halt_reason !== 2'd3) begin errors++; $display("FAIL lim_reason: got %0d want 3", halt_reason); end
   endtask

   task automatic test_bp_limit;
      do_reset();
      bp_en = 1'b1;
      bp_addr = 32'd36;
      max_commits = 32'd10;
      run_until_halt(100);
      checks++; if (halt_reason !== 2'd2) begin errors++; $display("FAIL bl_reason: got %0d want 2", halt_reason); end
      checks++; if (commit_cnt !== 32'd9 || pc !== 32'd36) begin errors++; $display("FAIL bl_commit: cnt=%0d pc=%0d want 9 36", commit_cnt, pc); end
      bp_en = 1'b0;
   endtask

   task automatic test_dump(input bit stall, input bit from_halt);
      logic  pv;
      beat_t pb, got;
      cmd_dump = 1'b1;
      for (int i = 0; i < 32; i++) sb.push_back('{last: i == 31, idx: 5'(i), data: rf[i]});
      cyc();
      cmd_dump = 1'b0;
      pv = 1'b0;
      pb = '0;
      for (int c = 0; c < 400 && sb.size() > 0; c++) begin
         dump_ready = stall ? (c % 3) != 0 : 1'b1;
         @(negedge clk);
         got = '{last: dump_last, idx: dump_idx, data: dump_data};
         checks++; if (cpu_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dump_busy: cpu_en=%b busy=%b want 0 1", cpu_en, busy); end
         if (dump_valid) begin
            if (pv) begin
               checks++; if (got !== pb) begin errors++; $display("FAIL dump_stable: got %h want %h", got, pb); end
            end
            checks++; if (got !== sb[0]) begin errors++; $display("FAIL dump_beat: got last=%b idx=%0d data=%h want last=%b idx=%0d data=%h", got.last, got.idx, got.data, sb[0].last, sb[0].idx, sb[0].data); end
            if (dump_ready) void'(sb.pop_front());
         end
         pv = dump_valid && !dump_ready;
         pb = got;
         cyc();
      end
      dump_ready = 1'b0;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL dump_timeout: %0d beats left want 0", sb.size()); end
      sb.delete();
      checks++; if (busy !== 1'b0 || halted !== from_halt || dump_valid !== 1'b0) begin errors++; $display("FAIL dump_return: busy=%b halted=%b valid=%b want 0 %b 0", busy, halted, dump_valid, from_halt); end
   endtask

   task automatic test_reset_mid_dump;
      cmd_dump = 1'b1;
      cyc();
      cmd_dump = 1'b0;
      dump_ready = 1'b1;
      for (int c = 0; c < 200 && !(dump_valid && dump_idx == 5'd10); c++) cyc();
      checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd10) begin errors++; $display("FAIL mid_reach: valid=%b idx=%0d want 1 10", dump_valid, dump_idx); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (dump_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL mid_reset: valid=%b busy=%b halted=%b want 0 0 0", dump_valid, busy, halted); end
      checks++; if (halt_reason !== 2'd0 || reg_sel !== 5'd0) begin errors++; $display("FAIL mid_regs: reason=%0d sel=%0d want 0 0", halt_reason, reg_sel); end
      dump_ready = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();
      test_dump(1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h9E3779B9 * 32'(i);
      test_reset();
      test_step();
      test_breakpoint();
      test_halt_run();
      test_limit();
      test_bp_limit();
      test_dump(1'b1, 1'b1);
      checks++; if (halt_reason !== 2'd2) begin errors++; $display("FAIL dump_reason: got %0d want 2", halt_reason); end
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
